// File: rtl/mac_pe_pkg.sv
// Shared defaults, FSM state encoding and saturation limits for the mac_pe block.
package mac_pe_pkg;

  localparam int unsigned DATA_BIT_DEF = 16;
  localparam int unsigned TAPS_DEF     = 3;
  localparam int unsigned ACC_BIT_DEF  = 2 * DATA_BIT_DEF + 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Signed accumulator limits at the default width
  localparam logic signed [ACC_BIT_DEF-1:0] SAT_MAX = {1'b0, {(ACC_BIT_DEF-1){1'b1}}};
  localparam logic signed [ACC_BIT_DEF-1:0] SAT_MIN = {1'b1, {(ACC_BIT_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_pe_shreg.sv
// Signed shift register bank: entry 0 takes din, entry k takes entry k-1 on en.
module mac_pe_shreg
  import mac_pe_pkg::*;
#(
  parameter int unsigned W     = DATA_BIT_DEF,
  parameter int unsigned DEPTH = TAPS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [W-1:0]        din,
  output logic [DEPTH-1:0][W-1:0]    q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (en) begin
      q <= {q[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Single-multiplier MAC processing element: TAPS-long dot product of weight and feature banks.
// Define MAC_PE_SAT_EN to saturate each accumulate step instead of wrapping.
module mac_pe
  import mac_pe_pkg::*;
#(
  parameter int unsigned DATA_BIT = DATA_BIT_DEF,
  parameter int unsigned TAPS     = TAPS_DEF,
  parameter int unsigned ACC_BIT  = 2 * DATA_BIT + 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       w_w,
  input  logic signed [DATA_BIT-1:0] w_in,
  input  logic                       if_w,
  input  logic signed [DATA_BIT-1:0] if_in,
  input  logic                       start,
  input  logic                       acc_mode,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       busy,
  output logic signed [ACC_BIT-1:0]  out
);

  localparam int unsigned PROD_BIT = 2 * DATA_BIT;
  localparam int unsigned TAP_W    = $clog2(TAPS);

  state_e                     state, state_nxt;
  logic [TAP_W-1:0]           tap, tap_nxt;
  logic signed [ACC_BIT-1:0]  acc, acc_nxt, acc_step, out_nxt, prod_ext;
  logic                       out_valid_nxt;
  logic [TAPS-1:0][DATA_BIT-1:0] w_bank, f_bank;
  logic signed [DATA_BIT-1:0] w_sel, f_sel;
  logic signed [PROD_BIT-1:0] prod;

  mac_pe_shreg #(.W(DATA_BIT), .DEPTH(TAPS)) u_w_bank (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (w_w && (state == IDLE)),
    .din   (w_in),
    .q     (w_bank)
  );

  mac_pe_shreg #(.W(DATA_BIT), .DEPTH(TAPS)) u_f_bank (
    .clk   (clk),
    .rst   (clear ? 1'b1 : rst),
    .clear (1'b0),
    .en    (if_w && (state == IDLE)),
    .din   (if_in),
    .q     (f_bank)
  );

  // Tap select mux; out-of-range counter values read as zero
  always_comb begin
    w_sel = '0;
    f_sel = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      if (tap == TAP_W'(k)) begin
        w_sel = $signed(w_bank[k]);
        f_sel = $signed(f_bank[k]);
      end
    end
  end

  assign prod     = PROD_BIT'(w_sel) * PROD_BIT'(f_sel);
  assign prod_ext = ACC_BIT'(prod);

`ifdef MAC_PE_SAT_EN
  localparam logic signed [ACC_BIT-1:0] ACC_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] ACC_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};
  logic signed [ACC_BIT:0] sum;

  // One guard bit exposes overflow of the signed add
  always_comb begin
    sum = (ACC_BIT+1)'(acc) + (ACC_BIT+1)'(prod_ext);
    if (sum[ACC_BIT] != sum[ACC_BIT-1]) begin
      acc_step = sum[ACC_BIT] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_step = sum[ACC_BIT-1:0];
    end
  end
`else
  always_comb begin
    acc_step = acc + prod_ext;
  end
`endif

  // Next-state and datapath update
  always_comb begin
    state_nxt     = state;
    tap_nxt       = tap;
    acc_nxt       = acc;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COMPUTE;
          tap_nxt   = '0;
          acc_nxt   = acc_mode ? acc : '0;
        end
      end
      COMPUTE: begin
        acc_nxt = acc_step;
        tap_nxt = tap + TAP_W'(1);
        if (tap == TAP_W'(TAPS - 1)) begin
          state_nxt     = DONE;
          out_nxt       = acc_step;
          out_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt     = IDLE;
      tap_nxt       = '0;
      acc_nxt       = '0;
      out_nxt       = '0;
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tap       <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tap       <= tap_nxt;
      acc       <= acc_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe: directed corner cases plus randomized dot products
// against an arithmetic reference model; a 32-bit-accumulator instance shares the stimulus.
module tb_mac_pe;

  localparam int TB_TAPS = 3;
  localparam int A36     = 36;
  localparam int A32     = 32;

  logic        clk = 1'b0;
  logic        rst, clear, w_w, if_w, start, acc_mode, out_ready;
  logic [15:0] w_in, if_in;
  logic        out_valid, busy, out_valid32, busy32;
  logic [35:0] out36;
  logic [31:0] out32;

  mac_pe #(.DATA_BIT(16), .TAPS(TB_TAPS), .ACC_BIT(A36)) dut (
    .clk(clk), .rst(rst), .clear(clear), .w_w(w_w), .w_in(w_in), .if_w(if_w), .if_in(if_in),
    .start(start), .acc_mode(acc_mode), .out_ready(out_ready),
    .out_valid(out_valid), .busy(busy), .out(out36)
  );

  mac_pe #(.DATA_BIT(16), .TAPS(TB_TAPS), .ACC_BIT(A32)) dut32 (
    .clk(clk), .rst(rst), .clear(clear), .w_w(w_w), .w_in(w_in), .if_w(if_w), .if_in(if_in),
    .start(start), .acc_mode(acc_mode), .out_ready(out_ready),
    .out_valid(out_valid32), .busy(busy32), .out(out32)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     mw[TB_TAPS];
  int     mf[TB_TAPS];
  longint r36, r32;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  // Fit an exact value into a signed w-bit accumulator
  function automatic longint fit(input longint v, input int w);
    longint hi, lo, m;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
`ifdef MAC_PE_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    m = longint'(1) <<< w;
    v = v & (m - 1);
    if (v > hi) v = v - m;
    return v;
`endif
  endfunction

  function automatic longint dot(input longint init, input int w);
    longint a;
    a = init;
    for (int k = 0; k < TB_TAPS; k++) a = fit(a + longint'(mw[k]) * longint'(mf[k]), w);
    return a;
  endfunction

  function automatic void model_shift(input int wv, input int fv, input bit ww, input bit fw);
    if (ww) begin
      for (int k = TB_TAPS - 1; k > 0; k--) mw[k] = mw[k-1];
      mw[0] = wv;
    end
    if (fw) begin
      for (int k = TB_TAPS - 1; k > 0; k--) mf[k] = mf[k-1];
      mf[0] = fv;
    end
  endfunction

  function automatic void model_flush();
    for (int k = 0; k < TB_TAPS; k++) begin
      mw[k] = 0;
      mf[k] = 0;
    end
    r36 = 0;
    r32 = 0;
  endfunction

  task automatic write(input int wv, input int fv, input bit ww, input bit fw);
    w_in = 16'(wv);
    if_in = 16'(fv);
    w_w = ww;
    if_w = fw;
    tick();
    w_w = 1'b0;
    if_w = 1'b0;
    model_shift(wv, fv, ww, fw);
  endtask

  task automatic do_dot(input bit mode, input bit wr, input int wv, input int fv, input int hold);
    longint e36, e32;
    int n;
    if (wr) begin
      w_in = 16'(wv);
      if_in = 16'(fv);
      w_w = 1'b1;
      if_w = 1'b1;
      model_shift(wv, fv, 1'b1, 1'b1);
    end
    start = 1'b1;
    acc_mode = mode;
    tick();
    start = 1'b0;
    w_w = 1'b0;
    if_w = 1'b0;
    e36 = dot(mode ? r36 : 0, A36);
    e32 = dot(mode ? r32 : 0, A32);
    check("busy_after_start", longint'(busy), 1);
    n = 0;
    while (!out_valid && n < 4 * TB_TAPS) begin
      tick();
      n++;
    end
    check("latency", longint'(n), longint'(TB_TAPS));
    check("out36", longint'($signed(out36)), e36);
    check("out32", longint'($signed(out32)), e32);
    check("valid32", longint'(out_valid32), 1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      acc_mode = 1'($urandom);
      w_w = 1'b1;
      if_w = 1'b1;
      w_in = 16'($urandom);
      if_in = 16'($urandom);
      tick();
      check("hold_valid", longint'(out_valid), 1);
      check("hold_out", longint'($signed(out36)), e36);
    end
    start = 1'b0;
    w_w = 1'b0;
    if_w = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid", longint'(out_valid), 0);
    check("hs_busy", longint'(busy), 0);
    check("hs_out_kept", longint'($signed(out36)), e36);
    r36 = e36;
    r32 = e32;
  endtask

  initial begin
    int nw, ov_seen;
    rst = 1'b1; clear = 1'b0; w_w = 1'b0; if_w = 1'b0; start = 1'b0;
    acc_mode = 1'b0; out_ready = 1'b0; w_in = '0; if_in = '0;
    model_flush();
    tick();
    tick();
    rst = 1'b0;
    check("rst_out", longint'($signed(out36)), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);

    // Basic dot product
    write(1, 4, 1, 1);
    write(2, 5, 1, 1);
    write(3, 6, 1, 1);
    do_dot(1'b0, 1'b0, 0, 0, 0);
    check("basic_32", longint'($signed(out36)), 32);

    // Large negative products, then accumulate onto the previous result
    for (int i = 0; i < TB_TAPS; i++) write(-1, 32767, 1, 1);
    do_dot(1'b0, 1'b0, 0, 0, 0);
    check("neg_first", longint'($signed(out36)), -98301);
    do_dot(1'b1, 1'b0, 0, 0, 0);
    check("neg_accum", longint'($signed(out36)), -196602);

    // Backpressure: start and writes during DONE must be ignored
    do_dot(1'b0, 1'b0, 0, 0, 5);
    do_dot(1'b0, 1'b0, 0, 0, 0);
    check("banks_kept", longint'($signed(out36)), -98301);

    // Full-scale negative operands: overflow of the 32-bit accumulator
    for (int i = 0; i < TB_TAPS; i++) write(-32768, -32768, 1, 1);
    do_dot(1'b0, 1'b0, 0, 0, 0);
`ifdef MAC_PE_SAT_EN
    check("ovf_acc32", longint'($signed(out32)), 2147483647);
`else
    check("ovf_acc32", longint'($signed(out32)), -1073741824);
`endif
    check("ovf_acc36", longint'($signed(out36)), 64'sd3221225472);

    // Clear in the second compute cycle discards the run
    write(rnd16(), rnd16(), 1, 1);
    start = 1'b1;
    acc_mode = 1'b0;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_flush();
    check("clr_valid", longint'(out_valid), 0);
    check("clr_out", longint'($signed(out36)), 0);
    check("clr_busy", longint'(busy), 0);
    ov_seen = 0;
    for (int i = 0; i < TB_TAPS + 2; i++) begin
      tick();
      if (out_valid) ov_seen = 1;
    end
    check("clr_no_valid", longint'(ov_seen), 0);
    do_dot(1'b0, 1'b0, 0, 0, 0);
    check("clr_next_zero", longint'($signed(out36)), 0);

    // Reset beats clear and start mid-compute
    for (int i = 0; i < TB_TAPS; i++) write(rnd16(), rnd16(), 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    clear = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    model_flush();
    check("rst_mid_out", longint'($signed(out36)), 0);
    check("rst_mid_valid", longint'(out_valid), 0);
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_out32", longint'($signed(out32)), 0);
    do_dot(1'b1, 1'b0, 0, 0, 0);
    check("rst_next_zero", longint'($signed(out36)), 0);

    // Randomized writes and dot products, including write-with-start
    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++) write(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
      do_dot(1'($urandom), 1'($urandom), rnd16(), rnd16(), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_pe.md
MAC_PE -- requirements
Module: mac_pe

Interface
REQ-001 Parameter DATA_BIT, default 16: signed weight/feature width.
REQ-002 Parameter TAPS, default 3, legal 2..16: shift-register depth and taps per dot product.
REQ-003 Parameter ACC_BIT, default 2*DATA_BIT+4: signed accumulator and output width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 clear  in  1  synchronous flush of shift registers, accumulator and FSM.
REQ-007 w_w  in  1  weight shift enable.
REQ-008 w_in  in  DATA_BIT  signed weight input.
REQ-009 if_w  in  1  feature shift enable.
REQ-010 if_in  in  DATA_BIT  signed feature input.
REQ-011 start  in  1  single-cycle request to begin a dot product.
REQ-012 acc_mode  in  1  sampled with start: 1 adds to the previous result, 0 starts from zero.
REQ-013 out_ready  in  1  consumer accepts out.
REQ-014 out_valid  out  1  out holds a completed result.
REQ-015 busy  out  1  high in COMPUTE and DONE.
REQ-016 out  out  ACC_BIT  registered signed result.

Function
REQ-017 Weight and feature banks each SHALL be TAPS entries. On a write enable, each bank shifts: entry k gets entry k-1, and entry 0 gets the input. Writes take effect only in IDLE and are ignored while busy.
REQ-018 The FSM SHALL have three states:
- IDLE: start moves to COMPUTE.
- COMPUTE: advances to DONE after tap index TAPS-1.
- DONE: moves to IDLE on out_valid && out_ready.
REQ-019 On start in IDLE, the accumulator SHALL load 0 if acc_mode=0, else hold the last result. The tap counter SHALL load 0.
REQ-020 COMPUTE SHALL handle one tap per cycle with a single multiplier: acc += sign_extend(feature[k]*weight[k]), with k = 0..TAPS-1.
REQ-021 Latency: start sampled in cycle t SHALL give out_valid=1 in cycle t+TAPS+1, with out equal to the final accumulator value.
REQ-022 In DONE, out and out_valid SHALL hold stable until out_ready. The handshake cycle SHALL return to IDLE with out_valid=0. out keeps its last value.
REQ-023 start SHALL be ignored while busy.
REQ-024 If start and a write arrive in the same IDLE cycle, the write SHALL apply first: the dot product uses the shifted banks.
REQ-025 clear in any state SHALL do all of the following next cycle: zero both banks, the accumulator and out; set out_valid=0; go to IDLE. In-flight results are discarded.
REQ-026 Without saturation, arithmetic SHALL be two's-complement and wrap at ACC_BIT.

Reset
REQ-027 rst SHALL take priority over clear and start.
REQ-028 On rst, all bank entries, the accumulator, the tap counter and out SHALL be 0, with out_valid=0, busy=0 and the FSM in IDLE, by the next clock.

Configuration
REQ-029 With MAC_PE_SAT_EN defined, each accumulate step SHALL saturate to the signed ACC_BIT range (max 2^(ACC_BIT-1)-1, min -2^(ACC_BIT-1)). Without it, REQ-026 wrap applies.

Structure
REQ-030 Package mac_pe_pkg SHALL hold:
- the DATA_BIT, TAPS and ACC_BIT defaults;
- the FSM state enum (IDLE, COMPUTE, DONE);
- the saturation max/min constants.
REQ-031 Sub-module mac_pe_shreg, a parametrised signed enable shift register with clear, SHALL be instantiated twice, once for weights and once for features.

Verification (TAPS=3, DATA_BIT=16 unless stated)
REQ-032 Write w_in 1,2,3 and if_in 4,5,6, then start with acc_mode=0 -> out_valid 4 cycles later with out=32 (6*3+5*2+4*1).
REQ-033 All weights -1, all features 32767, start -> out=-98301. Then start with acc_mode=1 -> out=-196602.
REQ-034 Hold out_ready=0 for 5 cycles in DONE and pulse start and w_w -> out is stable, and the banks and result are unchanged after release.
REQ-035 Assert clear in the 2nd COMPUTE cycle -> no out_valid, out=0. The next start gives out=0.
REQ-036 ACC_BIT=32, all weights and features -32768, start -> out=2147483647 with MAC_PE_SAT_EN, and -1073741824 without it.
REQ-037 Assert rst mid-COMPUTE together with clear and start -> all outputs 0 and FSM in IDLE next cycle.
